reaction_timer: RTL
===================

// Module: reaction_timer
// PURPOSE
//  Millisecond reaction-timer controller; upstream of the HEX digit display path.
//  Runs on the 1 kHz ms_clk and drives six BCD digits d0..d5 (d0 = 1 ms units).
//  On a false start it raises blink_req so the display mux selects the blink stage.
//  Flow: random wait after start -> stimulus LED -> BCD count until stop -> hold.
// PARAMETERS
//  MIN_WAIT  1000  minimum random delay, ms
//  LFSR_SEED 12'hACE  nonzero reset seed of the 12-bit LFSR
// PORTS
//  ms_clk     in   1  1 kHz clock; all logic on posedge
//  Reset_n    in   1  synchronous active-low reset
//  start      in   1  start button, active-high, debounced, asynchronous to ms_clk
//  stop       in   1  stop button, active-high, debounced, asynchronous to ms_clk
//  led_stim   out  1  stimulus LED; high only in TIMING
//  blink_req  out  1  high in FALSE; display mux selects the blink stage
//  done       out  1  high in DONE
//  d0..d5     out  4  BCD digits, d5 = most significant
// BEHAVIOUR
//  - Reset (Reset_n low at posedge): state=IDLE, all outputs 0, digits 0.
//    The LFSR loads LFSR_SEED and the sync/edge registers clear. Reset overrides everything.
//  - start/stop each pass through a 2-FF synchronizer, then a rising-edge detector.
//    A pulse (start_p/stop_p) lasts 1 cycle, 3 cycles after the input rises.
//  - The LFSR is 12-bit Fibonacci with taps 12,11,10,4. It steps every cycle and never reaches 0.
//  - FSM:
//    IDLE   : start_p -> WAIT; digits cleared; wcnt <= MIN_WAIT + lfsr[10:0].
//    WAIT   : wcnt decrements each cycle.
//             stop_p -> FALSE (checked first).
//             wcnt==0 -> TIMING; digits held at 0.
//    TIMING : led_stim=1; the BCD counter increments once per cycle.
//             Cycle 1 after entry shows 000001.
//             stop_p -> DONE; digits freeze at the current value, no increment that cycle.
//    DONE   : done=1; digits hold; start_p -> WAIT with new wcnt and digits cleared.
//    FALSE  : blink_req=1; digits 0; start_p -> WAIT as from IDLE.
//  - BCD increment: a digit at 9 wraps to 0 and carries to the next digit.
//    At 999999 the count saturates (holds) and stays in TIMING.
//  - Simultaneous start_p and stop_p: stop_p wins in WAIT and TIMING, start_p wins in DONE, FALSE and IDLE.
//  - start_p in WAIT or TIMING is ignored. stop_p in IDLE, DONE or FALSE is ignored.
//  - wcnt is 13 bits wide; the maximum load is MIN_WAIT + 2047 = 3047.
//  - Outputs are registered; led_stim, done and blink_req are decoded from the state register.
// CONFIGURATION
//  HOLD_BEST_EN defined:
//    - An extra 24-bit BCD best register (reset 999999) is added.
//    - On TIMING->DONE, if the frozen count < best (BCD compare, d5 first), best is updated.
//    - In IDLE the digits show best; in FALSE they show 0.
//  HOLD_BEST_EN undefined: no best register; IDLE digits are 0. Ports are identical in both builds.
// TESTING
//  1 Reset_n low 2 cycles mid-TIMING -> next cycle state IDLE, d0..d5=0, led_stim=0, done=0.
//  2 start pulse (seed 12'hACE) -> WAIT; led_stim rises exactly MIN_WAIT+lfsr[10:0]+1 cycles
//    after start_p. A checker model computes the LFSR.
//  3 stop asserted 250 cycles after led_stim rises -> digits 000250 (+3 sync latency = 000253).
//    done=1 and digits hold for 1000 cycles.
//  4 stop during WAIT -> blink_req=1, led_stim never rises, digits 0.
//    A later start -> WAIT, blink_req=0.
//  5 TIMING run past 999999 (force counter to 999998) -> reads 999999 and holds.
//    stop -> DONE, 999999.
//  6 HOLD_BEST_EN: runs of 400 then 300 then 500 ms -> IDLE after re-reset is 999999.
//    Without re-reset, best shows 000303 in IDLE. Undefined build: IDLE digits 0.

Source files
------------

// File: rtl/reaction_timer.sv
// reaction_timer: millisecond reaction-timer controller on the 1 kHz ms_clk.
// A random wait follows start, then the stimulus LED lights and a six-digit BCD
// count runs until stop, then the count holds. A stop during the wait is a false
// start and raises blink_req.
// Optional build macro: HOLD_BEST_EN keeps the best (lowest) time and shows it in IDLE.
module reaction_timer #(
  parameter int unsigned MIN_WAIT  = 1000,
  parameter logic [11:0] LFSR_SEED = 12'hACE
) (
  input  logic       ms_clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       stop,
  output logic       led_stim,
  output logic       blink_req,
  output logic       done,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic [3:0] d5
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_TIMING,
    S_DONE,
    S_FALSE
  } state_t;

  localparam logic [23:0] BCD_MAX = 24'h999999;

  state_t      state_q, state_d;
  logic [12:0] wcnt_q, wcnt_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] idle_digits;
  logic [11:0] lfsr_q;
  logic [12:0] wait_load;

  logic start_s1, start_s2, start_s3, start_p;
  logic stop_s1, stop_s2, stop_s3, stop_p;

  // Two-flop synchronizers followed by registered rising-edge detectors
  always_ff @(posedge ms_clk) begin
    if (!Reset_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      start_p  <= 1'b0;
      stop_s1  <= 1'b0;
      stop_s2  <= 1'b0;
      stop_s3  <= 1'b0;
      stop_p   <= 1'b0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      start_p  <= start_s2 & ~start_s3;
      stop_s1  <= stop;
      stop_s2  <= stop_s1;
      stop_s3  <= stop_s2;
      stop_p   <= stop_s2 & ~stop_s3;
    end
  end

  // Free-running 12-bit Fibonacci LFSR, taps 12,11,10,4
  always_ff @(posedge ms_clk) begin
    if (!Reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3]};
    end
  end

`ifdef HOLD_BEST_EN
  logic [23:0] best_q;

  // Best time: packed BCD compares correctly as unsigned, most significant digit first
  always_ff @(posedge ms_clk) begin
    if (!Reset_n) begin
      best_q <= BCD_MAX;
    end else if (state_q == S_TIMING && stop_p && cnt_q < best_q) begin
      best_q <= cnt_q;
    end
  end

  assign idle_digits = best_q;
`else
  assign idle_digits = '0;
`endif

  assign wait_load = 13'(MIN_WAIT) + {2'b00, lfsr_q[10:0]};

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // State, wait counter and digit register
  always_ff @(posedge ms_clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait-count and digit logic
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = idle_digits;
        if (start_p) begin
          state_d = S_WAIT;
          wcnt_d  = wait_load;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (stop_p) begin
          state_d = S_FALSE;
          cnt_d   = '0;
        end else if (wcnt_q == '0) begin
          state_d = S_TIMING;
        end else begin
          wcnt_d = wcnt_q - 13'd1;
        end
      end
      S_TIMING: begin
        if (stop_p) begin
          state_d = S_DONE;
        end else if (cnt_q != BCD_MAX) begin
          cnt_d = bcd_inc(cnt_q);
        end
      end
      S_DONE: begin
        if (start_p) begin
          state_d = S_WAIT;
          wcnt_d  = wait_load;
          cnt_d   = '0;
        end
      end
      S_FALSE: begin
        cnt_d = '0;
        if (start_p) begin
          state_d = S_WAIT;
          wcnt_d  = wait_load;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign led_stim  = (state_q == S_TIMING);
  assign blink_req = (state_q == S_FALSE);
  assign done      = (state_q == S_DONE);

  assign d0 = cnt_q[3:0];
  assign d1 = cnt_q[7:4];
  assign d2 = cnt_q[11:8];
  assign d3 = cnt_q[15:12];
  assign d4 = cnt_q[19:16];
  assign d5 = cnt_q[23:20];

endmodule
